instr_fetch_ctrl: RTL and testbench
===================================

// Module: instr_fetch_ctrl
// PURPOSE
//   IF-stage sequencer for the byte-addressed, big-endian instruction memory.
//   Owns the PC, drives the imem address and captures the combinational 32-bit read into the IF/ID register.
//   Handles pipeline stall, branch/jump redirect, squash and illegal-address faults, and counts issued instructions.
// PARAMETERS
//   RESET_PC    32'h0000_0000  PC loaded on reset
//   IMEM_BYTES  16384          imem size in bytes; legal fetch iff pc <= IMEM_BYTES-4
//   BOOT_CYCLES 1              bubble cycles after reset before the first fetch (>=1)
// PORTS
//   clk            in   1   clock, rising edge
//   rst            in   1   synchronous reset, active-high
//   imem_addr      out  32  byte address to imem (= pc), combinational from pc register
//   imem_data      in   32  imem read data, valid in the same cycle as imem_addr
//   stall          in   1   ID cannot accept; hold PC and IF/ID
//   redirect_valid in   1   branch/jump taken (from EX)
//   redirect_pc    in   32  redirect target byte address
//   flush          in   1   squash IF/ID contents this cycle
//   if_valid       out  1   IF/ID holds a real instruction
//   if_instr       out  32  IF/ID instruction
//   if_pc          out  32  IF/ID instruction address
//   if_pc_plus4    out  32  if_pc + 4 (mod 2^32)
//   fault          out  1   sticky illegal-fetch flag
//   fault_pc       out  32  address that faulted
//   fetch_count    out  32  instructions latched with if_valid=1 and not later squashed (wraps)
// BEHAVIOUR
//   Reset (rst=1 at edge, dominates all inputs, also mid-fault): pc=RESET_PC; state=BOOT;
//     boot counter=0; if_valid=0; if_instr=0; if_pc=0; if_pc_plus4=0; fault=0; fault_pc=0; fetch_count=0.
//   FSM states: BOOT, RUN, FAULT.
//   BOOT: if_valid=0, pc held; after BOOT_CYCLES edges -> RUN. Redirect in BOOT loads pc and stays in BOOT.
//   RUN, per edge, priority high->low:
//     1 redirect_valid: pc<=redirect_pc; if_valid<=0 (bubble) regardless of stall; IF/ID data don't-care.
//     2 illegal pc (pc[1:0]!=0 or pc>IMEM_BYTES-4): if stall, hold everything; else fault<=1,
//       fault_pc<=pc, if_valid<=0, -> FAULT. No imem data latched.
//     3 stall: pc and IF/ID held; flush during stall still clears if_valid.
//     4 else: if_instr<=imem_data, if_pc<=pc, if_pc_plus4<=pc+4, if_valid<=~flush, pc<=pc+4.
//   flush without redirect: only the entry being latched/held is squashed; pc still advances per rule 4.
//   fetch_count increments on every edge where if_valid becomes/remains 1 for a new
//     instruction (rule 4 with flush=0); never on held or squashed entries.
//   FAULT: if_valid=0; pc held; stall/flush ignored; fault stays 1.
//     redirect_valid -> pc<=redirect_pc, -> RUN, fault stays 1 (cleared only by rst), fault_pc held.
//   Latency: imem_data at pc in cycle N appears on if_instr after edge N (1 cycle); redirect costs 1 bubble.
//   Arithmetic: pc+4 in 32 bits, wraps 0xFFFF_FFFC->0, which is still legal-checked normally.
//   Outputs are registered except imem_addr.
// TESTING
//   imem model: 0x49400000@0, 0x49410004@4, 0x49420008@8, 0x2400000A@12; RESET_PC=0, BOOT_CYCLES=1.
//   T1 reset, no stall: if_valid=0 for 1 cycle, then if_instr 49400000/49410004/49420008 with if_pc 0/4/8;
//      fetch_count=3 after 3 fetches.
//   T2 stall asserted 3 cycles while IF/ID=pc 4: if_instr=49410004, imem_addr=8 held; release -> 49420008 next.
//   T3 redirect_valid with redirect_pc=12 and stall=1 together: next edge if_valid=0, pc=12;
//      following edge if_instr=2400000A, if_pc=12.
//   T4 redirect_pc=16382: fault=1, fault_pc=16382, if_valid=0; redirect to 0 -> RUN and fetch 49400000, fault still 1.
//   T5 pc reaches 16384 (IMEM_BYTES=16384 preload): fault, fault_pc=16384; rst mid-FAULT -> all outputs reset values.
//   T6 flush=1 on a normal fetch of pc 8: if_valid=0, pc=12, fetch_count not incremented.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// IF-stage sequencer: owns the PC, drives the byte-addressed imem and fills the IF/ID register.
// Handles stall, redirect, flush, illegal-address faults and counts issued instructions.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES  = 16384,
  parameter int unsigned BOOT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        flush,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam int unsigned BOOT_W  = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

  state_t              state;
  logic [31:0]         pc;
  logic [BOOT_W-1:0]   boot_cnt;
  logic                pc_illegal;

  assign imem_addr  = pc;
  assign pc_illegal = (pc[1:0] != 2'b00) || (pc > LAST_PC);

  // NOTE: every register here is written with <= so all updates take effect together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      boot_cnt    <= '0;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_plus4 <= '0;
      fault       <= 1'b0;
      fault_pc    <= '0;
      fetch_count <= '0;
    end else begin
      case (state)
        BOOT: begin
          if_valid <= 1'b0;
          if (redirect_valid) begin
            pc <= redirect_pc;
          end else if (boot_cnt == BOOT_W'(BOOT_CYCLES - 1)) begin
            state <= RUN;
          end else begin
            boot_cnt <= boot_cnt + 1'b1;
          end
        end

        RUN: begin
          if (redirect_valid) begin
            // Taken branch always costs a bubble, even under stall; IF/ID data is left as-is.
            pc       <= redirect_pc;
            if_valid <= 1'b0;
          end else if (pc_illegal) begin
            if (!stall) begin
              fault    <= 1'b1;
              fault_pc <= pc;
              if_valid <= 1'b0;
              state    <= FAULT;
            end
          end else if (stall) begin
            if (flush) if_valid <= 1'b0;
          end else begin
            if_instr    <= imem_data;
            if_pc       <= pc;
            if_pc_plus4 <= pc + 32'd4;
            if_valid    <= ~flush;
            pc          <= pc + 32'd4;
            if (!flush) fetch_count <= fetch_count + 32'd1;
          end
        end

        FAULT: begin
          // Fault flag is sticky until reset; only a redirect resumes fetching.
          if_valid <= 1'b0;
          if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= RUN;
          end
        end

        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: a cycle-level reference model checked on every falling edge,
// plus literal expectations for each scenario.
module tb_instr_fetch_ctrl;

  localparam int unsigned IMEM_BYTES  = 16384;
  localparam int unsigned BOOT_CYCLES = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        flush = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h4940_0000;
      32'd4:   return 32'h4941_0004;
      32'd8:   return 32'h4942_0008;
      32'd12:  return 32'h2400_000A;
      default: return 32'hC0DE_0000 ^ a;
    endcase
  endfunction

  assign imem_data = imem_word(imem_addr);

  instr_fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_BYTES (IMEM_BYTES),
    .BOOT_CYCLES(BOOT_CYCLES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .flush         (flush),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_pc_plus4   (if_pc_plus4),
    .fault         (fault),
    .fault_pc      (fault_pc),
    .fetch_count   (fetch_count)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: boot bubbles remaining, a halted-after-fault flag, and the visible registers.
  int          m_boot_left = 0;
  bit          m_halted = 1'b0;
  bit          m_started = 1'b0;
  logic [31:0] m_pc = '0;
  bit          m_valid = 1'b0;
  logic [31:0] m_instr = '0, m_ipc = '0, m_ipc4 = '0;
  bit          m_fault = 1'b0;
  logic [31:0] m_fault_pc = '0, m_count = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_started   = 1'b1;
      m_boot_left = BOOT_CYCLES;
      m_halted    = 1'b0;
      m_pc        = 32'h0;
      m_valid     = 1'b0;
      m_instr     = '0;
      m_ipc       = '0;
      m_ipc4      = '0;
      m_fault     = 1'b0;
      m_fault_pc  = '0;
      m_count     = '0;
    end else if (m_boot_left > 0) begin
      m_valid = 1'b0;
      if (redirect_valid) m_pc = redirect_pc;
      else m_boot_left--;
    end else if (m_halted) begin
      m_valid = 1'b0;
      if (redirect_valid) begin
        m_pc     = redirect_pc;
        m_halted = 1'b0;
      end
    end else if (redirect_valid) begin
      m_pc    = redirect_pc;
      m_valid = 1'b0;
    end else if ((m_pc % 4) != 0 || longint'(m_pc) > longint'(IMEM_BYTES) - 4) begin
      if (!stall) begin
        m_fault    = 1'b1;
        m_fault_pc = m_pc;
        m_valid    = 1'b0;
        m_halted   = 1'b1;
      end
    end else if (stall) begin
      if (flush) m_valid = 1'b0;
    end else begin
      m_instr = imem_word(m_pc);
      m_ipc   = m_pc;
      m_ipc4  = m_pc + 32'd4;
      m_valid = !flush;
      if (!flush) m_count = m_count + 1;
      m_pc    = m_pc + 32'd4;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("mdl.imem_addr", imem_addr, m_pc);
      check("mdl.if_valid", 32'(if_valid), 32'(m_valid));
      check("mdl.fault", 32'(fault), 32'(m_fault));
      check("mdl.fault_pc", fault_pc, m_fault_pc);
      check("mdl.fetch_count", fetch_count, m_count);
      if (m_valid) begin
        check("mdl.if_instr", if_instr, m_instr);
        check("mdl.if_pc", if_pc, m_ipc);
        check("mdl.if_pc_plus4", if_pc_plus4, m_ipc4);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic expect_reset_values(input string tag);
    check({tag, ".if_valid"}, 32'(if_valid), 32'd0);
    check({tag, ".if_instr"}, if_instr, 32'd0);
    check({tag, ".if_pc"}, if_pc, 32'd0);
    check({tag, ".if_pc_plus4"}, if_pc_plus4, 32'd0);
    check({tag, ".fault"}, 32'(fault), 32'd0);
    check({tag, ".fault_pc"}, fault_pc, 32'd0);
    check({tag, ".fetch_count"}, fetch_count, 32'd0);
    check({tag, ".imem_addr"}, imem_addr, 32'd0);
  endtask

  initial begin
    // T1: reset, boot bubble, three straight fetches
    tick(1);
    do_reset();
    expect_reset_values("t1.rst");
    tick(1);
    check("t1.boot_bubble", 32'(if_valid), 32'd0);
    tick(1);
    check("t1.i0", if_instr, 32'h4940_0000);
    check("t1.pc0", if_pc, 32'd0);
    check("t1.v0", 32'(if_valid), 32'd1);
    tick(1);
    check("t1.i1", if_instr, 32'h4941_0004);
    check("t1.pc1", if_pc, 32'd4);
    tick(1);
    check("t1.i2", if_instr, 32'h4942_0008);
    check("t1.pc2", if_pc, 32'd8);
    check("t1.pc2p4", if_pc_plus4, 32'd12);
    check("t1.count", fetch_count, 32'd3);

    // T2: stall for 3 cycles with IF/ID holding pc 4
    do_reset();
    tick(3);
    check("t2.pre", if_pc, 32'd4);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("t2.hold_instr", if_instr, 32'h4941_0004);
      check("t2.hold_addr", imem_addr, 32'd8);
    end
    check("t2.count_held", fetch_count, 32'd2);
    stall = 1'b0;
    tick(1);
    check("t2.release", if_instr, 32'h4942_0008);
    check("t2.count", fetch_count, 32'd3);

    // T3: redirect wins over stall
    redirect_valid = 1'b1; redirect_pc = 32'd12; stall = 1'b1;
    tick(1);
    check("t3.bubble", 32'(if_valid), 32'd0);
    check("t3.pc", imem_addr, 32'd12);
    redirect_valid = 1'b0; stall = 1'b0;
    tick(1);
    check("t3.instr", if_instr, 32'h2400_000A);
    check("t3.ifpc", if_pc, 32'd12);

    // T4: misaligned/out-of-range redirect faults; redirect to 0 resumes with fault sticky
    redirect_valid = 1'b1; redirect_pc = 32'd16382;
    tick(1);
    redirect_valid = 1'b0;
    tick(1);
    check("t4.fault", 32'(fault), 32'd1);
    check("t4.fault_pc", fault_pc, 32'd16382);
    check("t4.valid", 32'(if_valid), 32'd0);
    stall = 1'b1; flush = 1'b1;
    tick(2);
    check("t4.held_pc", imem_addr, 32'd16382);
    stall = 1'b0; flush = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    tick(1);
    redirect_valid = 1'b0;
    tick(1);
    check("t4.resume", if_instr, 32'h4940_0000);
    check("t4.resume_v", 32'(if_valid), 32'd1);
    check("t4.sticky", 32'(fault), 32'd1);
    check("t4.fpc_held", fault_pc, 32'd16382);

    // T5: run off the end of imem; stalled illegal pc holds, then faults; reset mid-fault
    do_reset();
    tick(1);
    redirect_valid = 1'b1; redirect_pc = 32'd16376;
    tick(1);
    redirect_valid = 1'b0;
    tick(2);
    check("t5.last_pc", if_pc, 32'd16380);
    check("t5.last_instr", if_instr, 32'hC0DE_0000 ^ 32'd16380);
    check("t5.addr", imem_addr, 32'd16384);
    stall = 1'b1;
    tick(1);
    check("t5.stall_nofault", 32'(fault), 32'd0);
    stall = 1'b0;
    tick(1);
    check("t5.fault", 32'(fault), 32'd1);
    check("t5.fault_pc", fault_pc, 32'd16384);
    tick(1);
    do_reset();
    expect_reset_values("t5.rst");

    // T6: flush on a normal fetch of pc 8, then flush under stall
    tick(3);
    flush = 1'b1;
    tick(1);
    check("t6.squash", 32'(if_valid), 32'd0);
    check("t6.pc", imem_addr, 32'd12);
    check("t6.count", fetch_count, 32'd2);
    flush = 1'b0;
    tick(1);
    check("t6.next", if_instr, 32'h2400_000A);
    check("t6.count2", fetch_count, 32'd3);
    stall = 1'b1; flush = 1'b1;
    tick(1);
    check("t6.stall_flush", 32'(if_valid), 32'd0);
    check("t6.stall_pc", imem_addr, 32'd16);
    stall = 1'b0; flush = 1'b0;
    tick(1);
    check("t6.after", if_pc, 32'd16);
    check("t6.count3", fetch_count, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
